ps2_kbd_rx: RTL
===============

# ps2_kbd_rx

Parametrised PS/2 keyboard receiver for the DE2_115 demonstrations. It samples the PS/2 clock and data lines in the iCLK_50 domain, deglitches them, and checks each 11-bit frame (start, 8 data, odd parity, stop). Good bytes are optionally folded with E0/F0 prefixes into make/break codes and queued in a show-ahead FIFO with a valid/ready handshake. It replaces free-running bit counters clocked from the PS/2 line, so synthesizer and other consumers get framed, error-checked key events.

## Interface

Parameters:

- FILT_LEN, 8: consecutive equal samples needed before a filtered line changes (1..255).
- TIMEOUT_CYC, 100000: iCLK_50 cycles without a filtered clock fall before an open frame is aborted (2 ms).
- FIFO_AW, 3: FIFO address width; depth is 2^FIFO_AW entries.
- DECODE_EN, 1: 1 = fold E0/F0 prefixes into flags; 0 = push every byte raw with flags 0.

Ports:

- iCLK_50  in  1  system clock, 50 MHz.
- iRST_n  in  1  reset, asynchronous, active-low.
- PS2_CLK  inout  1  PS/2 clock; never driven, held at high-Z.
- PS2_DAT  inout  1  PS/2 data; never driven, held at high-Z.
- oCODE  out  8  scan code at FIFO head.
- oEXT  out  1  head entry was preceded by E0.
- oBREAK  out  1  head entry was preceded by F0 (key release).
- oVALID  out  1  FIFO not empty.
- iREADY  in  1  consumer accepts head entry.
- oFIFO_CNT  out  FIFO_AW+1  current occupancy.
- oPAR_ERR  out  1  one-cycle pulse: parity error.
- oFRM_ERR  out  1  one-cycle pulse: bad start/stop bit or timeout.
- oOVF  out  1  one-cycle pulse: entry dropped because FIFO full.
- oRX_BUSY  out  1  frame in progress (state not IDLE).

## Operation

- Input path: 2-FF synchronizer per line, then a filter counter per line. The filtered value takes the synced value after FILT_LEN consecutive equal samples. The filtered values reset to 1.
- Sample event: filtered clock 1->0 transition, one cycle wide. Data is the filtered data value in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a sample with data=0, clear the shift register and bit count, go to DATA. On a sample with data=1, pulse oFRM_ERR and stay in IDLE.
  - DATA: shift LSB first. After the 8th sample, go to PARITY.
  - PARITY: store the bit and go to STOP. Parity is good when the 8 data bits plus the parity bit contain an odd number of ones.
  - STOP: on a sample, return to IDLE.
    - Data=0: pulse oFRM_ERR, discard the byte.
    - Data=1 and parity bad: pulse oPAR_ERR, discard the byte.
    - Otherwise: byte accepted.
- Timeout: an idle counter clears on every sample event and counts while the state is not IDLE. At TIMEOUT_CYC it forces IDLE, pulses oFRM_ERR, and discards partial data.
- Decoder (DECODE_EN=1):
  - Accepted 0xE0 sets ext_pend; accepted 0xF0 sets brk_pend. Neither is pushed.
  - Any other byte pushes {ext_pend, brk_pend, byte}, then clears both pend flags.
  - Any parity, frame, or timeout error clears both pend flags.
- Decoder (DECODE_EN=0): every accepted byte is pushed with flags 0.
- FIFO: 10 bits wide, show-ahead; outputs always reflect the head entry.
  - Pop occurs when oVALID && iREADY.
  - A push while full with no pop in the same cycle is dropped and pulses oOVF.
  - A push and a pop in the same cycle while full both succeed; count stays at full.
  - Read and write pointers wrap modulo 2^FIFO_AW. oFIFO_CNT counts 0..2^FIFO_AW.

## Timing

- Reset values:
  - oCODE=0, oEXT=0, oBREAK=0, oVALID=0, oFIFO_CNT=0.
  - All error pulses 0, oRX_BUSY=0.
  - State IDLE, pend flags 0, FIFO empty.
- Line-to-sample latency: 2 sync cycles + FILT_LEN cycles, from a pad edge to the sample event.
- Sample event of the stop bit -> push in the next cycle -> oVALID high and head updated one cycle after the push. Total: 2 cycles.
- Error pulses assert in the cycle after the offending sample event or timeout, and last exactly one cycle.
- Asserting iRST_n low mid-frame or with a non-empty FIFO immediately returns every output to its reset value. No partial byte survives reset.

## Test plan

- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz PS/2 clock -> one entry {ext 0, brk 0, 0x1C}, oVALID rises 2 cycles after the stop sample, no error pulses.
- Bytes E0, F0, 75 with DECODE_EN=1 -> one entry {ext 1, brk 1, 0x75}. Same stimulus with DECODE_EN=0 -> three entries E0, F0, 75 with flags 0.
- Frame 0x1C with parity bit 1 -> oPAR_ERR single pulse, no push. A following E0, 1C sequence pushes {ext 1, brk 0, 0x1C}.
- Stop line after 5 data bits and idle 2 ms -> oFRM_ERR once at TIMEOUT_CYC, oRX_BUSY falls. The next good frame 0x29 is received correctly.
- iREADY=0, nine good bytes 0x01..0x09 (FIFO_AW=3) -> oFIFO_CNT=8, oOVF once on 0x09. Draining yields 0x01..0x08 in order, then oVALID=0.
- 100 ns low glitches on PS2_CLK while idle (FILT_LEN=8, 160 ns) -> no sample events, no errors. Asserting iRST_n low mid-frame -> all outputs return to reset values, and the next frame is received cleanly.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch the lines, frame and check
// each byte, fold E0/F0 prefixes, and queue key events in a show-ahead FIFO.
module ps2_kbd_rx #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_AW     = 3,
    parameter int DECODE_EN   = 1
) (
    input  logic               iCLK_50,
    input  logic               iRST_n,
    inout  wire                PS2_CLK,
    inout  wire                PS2_DAT,
    output logic [7:0]         oCODE,
    output logic               oEXT,
    output logic               oBREAK,
    output logic               oVALID,
    input  logic               iREADY,
    output logic [FIFO_AW:0]   oFIFO_CNT,
    output logic               oPAR_ERR,
    output logic               oFRM_ERR,
    output logic               oOVF,
    output logic               oRX_BUSY
);

    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam logic [7:0]    FL = 8'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // The receiver only listens; the keyboard owns both lines.
    assign PS2_CLK = 1'bz;
    assign PS2_DAT = 1'bz;

    logic [1:0]      pad;
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      filt;
    logic [1:0][7:0] fcnt;
    logic            fall;
    logic            din;

    assign pad = {PS2_DAT, PS2_CLK};
    assign din = filt[1];

    // Bit 0 is the clock line, bit 1 the data line.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            s1   <= 2'b11;
            s2   <= 2'b11;
            filt <= 2'b11;
            fcnt <= '0;
            fall <= 1'b0;
        end else begin
            s1   <= pad;
            s2   <= s1;
            fall <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FL) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                    if (i == 0) fall <= ~s2[i];
                end else begin
                    fcnt[i] <= fcnt[i] + 8'd1;
                end
            end
        end
    end

    state_t        state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tocnt_q, tocnt_d;
    logic          perr_d, ferr_d, acc_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        par_d   = par_q;
        tocnt_d = tocnt_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        acc_d   = 1'b0;
        if (fall) begin
            tocnt_d = '0;
        end else if (state_q != IDLE) begin
            tocnt_d = tocnt_q + TW'(1);
        end
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!din) begin
                        shreg_d = '0;
                        bcnt_d  = '0;
                        state_d = DATA;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d = {din, shreg_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!din) ferr_d = 1'b1;
                    else if (!(^{shreg_q, par_q})) perr_d = 1'b1;
                    else acc_d = 1'b1;
                end
            endcase
        end else if (state_q != IDLE && tocnt_q == TO) begin
            state_d = IDLE;
            tocnt_d = '0;
            shreg_d = '0;
            bcnt_d  = '0;
            ferr_d  = 1'b1;
        end
    end

    logic       acc_q;
    logic [7:0] byte_q;

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bcnt_q   <= '0;
            par_q    <= 1'b0;
            tocnt_q  <= '0;
            oPAR_ERR <= 1'b0;
            oFRM_ERR <= 1'b0;
            acc_q    <= 1'b0;
            byte_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bcnt_q   <= bcnt_d;
            par_q    <= par_d;
            tocnt_q  <= tocnt_d;
            oPAR_ERR <= perr_d;
            oFRM_ERR <= ferr_d;
            acc_q    <= acc_d;
            if (acc_d) byte_q <= shreg_q;
        end
    end

    assign oRX_BUSY = (state_q != IDLE);

    logic       ext_pend, brk_pend;
    logic       is_pfx;
    logic       push;
    logic [9:0] push_data;

    assign is_pfx = (byte_q == 8'hE0) || (byte_q == 8'hF0);

    always_comb begin
        push      = 1'b0;
        push_data = {2'b00, byte_q};
        if (DECODE_EN != 0) begin
            push      = acc_q && !is_pfx;
            push_data = {ext_pend, brk_pend, byte_q};
        end else begin
            push = acc_q;
        end
    end

    // Any line error breaks a prefix sequence, so pending flags are dropped.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (oPAR_ERR || oFRM_ERR) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (acc_q && DECODE_EN != 0) begin
            if (byte_q == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [CW-1:0]      cnt_q;
    logic               pop, full, wr;

    assign oVALID    = (cnt_q != '0);
    assign oFIFO_CNT = cnt_q;
    assign pop       = oVALID && iREADY;
    assign full      = (cnt_q == CW'(DEPTH));
    assign wr        = push && (!full || pop);
    assign {oEXT, oBREAK, oCODE} = oVALID ? mem[rptr] : 10'd0;

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
            oOVF  <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            cnt_q <= cnt_q + CW'(wr) - CW'(pop);
            oOVF  <= push && full && !pop;
        end
    end

endmodule
